bin_to_bcd_seq: RTL

//   Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method, one bit per clock.

---
 rtl/bcd_pkg.sv | 14 +
 rtl/bcd_digit_adj.sv | 17 +
 rtl/bin_to_bcd_seq.sv | 100 ++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared state encodings and BCD adjust constants
package bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } bcd_state_t;

    // Also used by the downstream Excess-3 stage
    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - combinational add-3 correction for one BCD digit
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // A digit of 5 or more would exceed 9 after the doubling shift, so pre-add 3
    always_comb begin
        dout = din;
        if (din >= BCD_ADJ_THRESH) begin
            dout = din + BCD_ADJ_ADD;
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential double-dabble binary to BCD converter
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  busy
);

    localparam int ACC_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_W);

    // The accumulator must be able to hold the largest input value
    if (!((10 ** DIGITS) > ((2 ** BIN_W) - 1))) begin : g_param_check
        $error("bin_to_bcd_seq: DIGITS too small for BIN_W");
    end

    bcd_state_t           state_q;
    bcd_state_t           state_d;
    logic [BIN_W-1:0]     binreg_q;
    logic [ACC_W-1:0]     accum_q;
    logic [CNT_W-1:0]     count_q;
    logic [ACC_W-1:0]     bcd_q;
    logic [ACC_W-1:0]     accum_adj;
    logic [ACC_W-1:0]     accum_shift;
    logic                 accept;
    logic                 last_iter;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (accum_q[4*g +: 4]),
            .dout (accum_adj[4*g +: 4])
        );
    end

    // Corrected digits shift left one place; the next binary MSB enters units LSB
    assign accum_shift = {accum_adj[ACC_W-2:0], binreg_q[BIN_W-1]};
    assign accept      = (state_q == ST_IDLE) && in_valid;
    assign last_iter   = (state_q == ST_SHIFT) && (count_q == CNT_W'(1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: accept in IDLE, iterate BIN_W times, wait for downstream in DONE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (in_valid)  state_d = ST_SHIFT;
            ST_SHIFT: if (last_iter) state_d = ST_DONE;
            ST_DONE:  if (out_ready) state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    // Shift datapath, iteration counter and result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            binreg_q <= '0;
            accum_q  <= '0;
            count_q  <= '0;
            bcd_q    <= '0;
        end else if (accept) begin
            binreg_q <= bin_in;
            accum_q  <= '0;
            count_q  <= CNT_LOAD;
        end else if (state_q == ST_SHIFT) begin
            binreg_q <= binreg_q << 1;
            accum_q  <= accum_shift;
            count_q  <= count_q - CNT_W'(1);
            if (last_iter) begin
                bcd_q <= accum_shift;
            end
        end
    end

    // Outputs decoded from the registered state; bcd_out holds the last result
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
        busy      = (state_q == ST_SHIFT) || (state_q == ST_DONE);
        bcd_out   = bcd_q;
    end

endmodule
